// File: rtl/onchip_memory_stream_reader.sv
// Streams a block of words out of an on-chip memory (fixed one-cycle read
// latency) onto a ready/valid packet stream. Reads are throttled so that every
// issued read always has a guaranteed FIFO slot when its data returns.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; word_count=0 completes immediately
// FETCH | issuing reads while reads remain and the FIFO has room
// DRAIN | all reads issued; waiting for the last word to be accepted
module onchip_memory_stream_reader #(
    parameter int ADDR_WIDTH = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_address,
    input  logic [ADDR_WIDTH:0]   word_count,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] address,
    output logic                  chipselect,
    output logic                  write,
    output logic [3:0]            byteenable,
    output logic                  clken,
    input  logic [31:0]           readdata,
    output logic [31:0]           st_data,
    output logic                  st_valid,
    input  logic                  st_ready,
    output logic                  st_startofpacket,
    output logic                  st_endofpacket
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_WIDTH:0] ONE = 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH:0]   count_q;
    logic [ADDR_WIDTH:0]   issued;
    logic [ADDR_WIDTH:0]   popped;
    logic [ADDR_WIDTH:0]   count_m1;
    logic                  inflight;

    logic [31:0]           fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      fifo_count;
    logic [CNT_W-1:0]      fifo_count_next;
    logic [CNT_W:0]        committed_next;
    logic                  push;
    logic                  pop;
    logic                  room;

    assign write      = 1'b0;
    assign byteenable = 4'hF;
    assign clken      = 1'b1;

    assign busy     = (state != IDLE);
    assign count_m1 = count_q - ONE;

    // Data returned for last cycle's read lands in the FIFO this cycle.
    assign push     = inflight;
    assign st_valid = (fifo_count != '0);
    assign pop      = st_valid & st_ready;
    assign st_data  = fifo_mem[rd_ptr];

    // Packet markers come from the pop counter, so they hold steady under backpressure.
    assign st_startofpacket = st_valid && (popped == '0);
    assign st_endofpacket   = st_valid && (popped == count_m1);

    // Slots that will be occupied next cycle: buffered words plus the read whose
    // data arrives next cycle. A new read may be issued only if one slot remains.
    always_comb begin
        fifo_count_next = fifo_count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
        committed_next  = {1'b0, fifo_count_next} + {{CNT_W{1'b0}}, chipselect};
        room            = committed_next < (CNT_W + 1)'(FIFO_DEPTH);
    end

    // Sequencer: accepts requests, issues reads, tracks delivery and signals completion.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            base_q     <= '0;
            count_q    <= '0;
            issued     <= '0;
            popped     <= '0;
            chipselect <= 1'b0;
            inflight   <= 1'b0;
            address    <= '0;
            done       <= 1'b0;
        end else begin
            done       <= 1'b0;
            inflight   <= chipselect;
            chipselect <= 1'b0;
            if (pop) begin
                popped <= popped + ONE;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        if (word_count == '0) begin
                            done <= 1'b1;
                        end else begin
                            base_q  <= base_address;
                            count_q <= word_count;
                            issued  <= '0;
                            popped  <= '0;
                            state   <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    if ((issued < count_q) && room) begin
                        chipselect <= 1'b1;
                        address    <= base_q + issued[ADDR_WIDTH-1:0];
                        issued     <= issued + ONE;
                        if (issued + ONE == count_q) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && (popped == count_m1)) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            fifo_count <= fifo_count_next;
        end
    end

    // FIFO storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= readdata;
        end
    end

endmodule

// File: tb/tb_onchip_memory_stream_reader.sv
// Scoreboard bench for onchip_memory_stream_reader: stimulus queues expected
// addresses and stream words; negedge monitors pop and compare.
module tb_onchip_memory_stream_reader;

    localparam int AW    = 12;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [AW-1:0] base_address;
    logic [AW:0]   word_count;
    logic          busy, done, chipselect, write, clken;
    logic [AW-1:0] address;
    logic [3:0]    byteenable;
    logic [31:0]   readdata;
    logic [31:0]   st_data;
    logic          st_valid, st_ready, st_startofpacket, st_endofpacket;

    onchip_memory_stream_reader #(.ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .base_address(base_address), .word_count(word_count),
        .busy(busy), .done(done), .address(address), .chipselect(chipselect),
        .write(write), .byteenable(byteenable), .clken(clken),
        .readdata(readdata), .st_data(st_data), .st_valid(st_valid),
        .st_ready(st_ready), .st_startofpacket(st_startofpacket),
        .st_endofpacket(st_endofpacket)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d;
        logic        sop;
        logic        eop;
    } exp_t;

    exp_t          exp_q[$];
    logic [AW-1:0] addr_q[$];
    int            tests = 0;
    int            fails = 0;
    int            done_expected = 0;
    int            outstanding = 0;
    bit            zero_flag = 0;
    bit            eop_prev = 0;
    bit            hold_flag = 0;
    exp_t          held;

    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        return {4'hD, a, 4'h5, ~a};
    endfunction

    // Memory model: one-cycle registered read.
    always @(posedge clk) begin
        if (chipselect) readdata <= mem_word(address);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: address order, stream words, stability, buffering bound, done.
    always @(negedge clk) begin
        if (!reset_n) begin
            hold_flag = 0;
            eop_prev  = 0;
        end else begin
            if (chipselect) begin
                outstanding++;
                if (addr_q.size() == 0) begin
                    chk("unexpected_chipselect", 32'(address), 32'hFFFF_FFFF);
                end else begin
                    chk("address", 32'(address), 32'(addr_q.pop_front()));
                end
            end
            if (hold_flag) begin
                chk("stall_valid", 32'(st_valid), 32'd1);
                chk("stall_data", st_data, held.d);
                chk("stall_sop_eop", {30'd0, st_startofpacket, st_endofpacket}, {30'd0, held.sop, held.eop});
            end
            if (st_valid && st_ready) begin
                outstanding--;
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", st_data, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("st_data", st_data, e.d);
                    chk("sop_eop", {30'd0, st_startofpacket, st_endofpacket}, {30'd0, e.sop, e.eop});
                end
            end
            if (chipselect) chk("buffer_bound", 32'(outstanding <= DEPTH), 32'd1);
            if (done) begin
                chk("done_expected", 32'(done_expected > 0), 32'd1);
                chk("done_timing", 32'(eop_prev || zero_flag), 32'd1);
                if (done_expected > 0) done_expected--;
                zero_flag = 0;
            end
            hold_flag = st_valid && !st_ready;
            held      = '{st_data, st_startofpacket, st_endofpacket};
            eop_prev  = st_valid && st_ready && st_endofpacket;
        end
    end

    task automatic start_xfer(input logic [AW-1:0] b, input logic [AW:0] n);
        @(posedge clk); #1;
        start = 1'b1; base_address = b; word_count = n;
        for (int i = 0; i < int'(n); i++) begin
            logic [AW-1:0] a;
            a = b + AW'(i);
            addr_q.push_back(a);
            exp_q.push_back('{mem_word(a), i == 0, i == int'(n) - 1});
        end
        done_expected++;
        if (n == '0) zero_flag = 1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input bit rnd);
        int i;
        for (i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (rnd) st_ready = 1'($urandom_range(0, 1));
            if (!busy && exp_q.size() == 0 && done_expected == 0) break;
        end
        st_ready = 1'b1;
        if (i == budget) begin
            fails++;
            $display("FAIL wait_idle: timeout, busy %0d words left %0d", busy, exp_q.size());
        end
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; base_address = '0; word_count = '0; st_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_cs", 32'(chipselect), 0);
        chk("rst_valid", 32'(st_valid), 0);
        chk("rst_sop_eop", {30'd0, st_startofpacket, st_endofpacket}, 0);
        chk("rst_address", 32'(address), 0);
        chk("tie_offs", {26'd0, write, byteenable, clken}, {26'd0, 1'b0, 4'hF, 1'b1});
        @(posedge clk); #1 reset_n = 1'b1;

        // Basic 4-word transfer with cycle-exact latency and throughput checks.
        start_xfer(12'h010, 13'd4);
        @(posedge clk); #1;
        chk("e1_cs", 32'(chipselect), 1); chk("e1_addr", 32'(address), 32'h010);
        chk("e1_busy", 32'(busy), 1); chk("e1_valid", 32'(st_valid), 0);
        @(posedge clk); #1;
        chk("e2_cs", 32'(chipselect), 1); chk("e2_valid", 32'(st_valid), 0);
        @(posedge clk); #1;
        chk("e3_cs", 32'(chipselect), 1); chk("e3_valid", 32'(st_valid), 1);
        @(posedge clk); #1;
        chk("e4_cs", 32'(chipselect), 1); chk("e4_addr", 32'(address), 32'h013);
        @(posedge clk); #1;
        chk("e5_cs", 32'(chipselect), 0); chk("e5_valid", 32'(st_valid), 1);
        @(posedge clk); #1;
        chk("e6_valid", 32'(st_valid), 1); chk("e6_done", 32'(done), 0);
        @(posedge clk); #1;
        chk("e7_done", 32'(done), 1); chk("e7_busy", 32'(busy), 0); chk("e7_valid", 32'(st_valid), 0);
        wait_idle(50, 0);

        // Address wrap at the top of memory.
        start_xfer(12'hFFE, 13'd4);
        wait_idle(50, 0);

        // Single word: SOP and EOP together.
        start_xfer(12'hABC, 13'd1);
        wait_idle(50, 0);

        // Zero-length request.
        start_xfer(12'h123, 13'd0);
        chk("zero_done", 32'(done), 1); chk("zero_busy", 32'(busy), 0); chk("zero_cs", 32'(chipselect), 0);
        @(posedge clk); #1;
        chk("zero_done_pulse", 32'(done), 0); chk("zero_busy2", 32'(busy), 0);
        wait_idle(20, 0);

        // Backpressure: stall after the first word for 20 cycles.
        start_xfer(12'h040, 13'd16);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (st_valid) break;
        end
        @(posedge clk); #1 st_ready = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("stall_cs_idle", 32'(chipselect), 0);
        chk("stall_busy", 32'(busy), 1);
        st_ready = 1'b1;
        wait_idle(100, 0);

        // Start while busy must be ignored.
        start_xfer(12'h100, 13'd8);
        @(posedge clk); #1;
        start = 1'b1; base_address = 12'h200; word_count = 13'd3;
        @(posedge clk); #1 start = 1'b0;
        wait_idle(100, 0);

        // Reset mid-transfer, then a fresh 2-word transfer.
        st_ready = 1'b0;
        start_xfer(12'h300, 13'd16);
        repeat (6) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_cs", 32'(chipselect), 0);
        chk("midrst_valid", 32'(st_valid), 0);
        exp_q.delete(); addr_q.delete();
        done_expected = 0; outstanding = 0; zero_flag = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_no_done", 32'(done), 0);
        reset_n = 1'b1; st_ready = 1'b1;
        start_xfer(12'h020, 13'd2);
        wait_idle(50, 0);

        // Full memory sweep with random backpressure.
        start_xfer(12'h800, 13'd4096);
        wait_idle(30000, 1);

        chk("final_queues", 32'(exp_q.size() + addr_q.size()), 0);
        chk("final_done_count", 32'(done_expected), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/onchip_memory_stream_reader.md
ONCHIP_MEMORY_STREAM_READER -- requirements
Module: onchip_memory_stream_reader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, the on-chip memory word-address width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4 (power of 2, at least 2), the output buffer depth in words.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 SHALL have port clk  input  1  sole clock; all logic rising-edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle transfer request.
REQ-007 SHALL have port base_address  input  ADDR_WIDTH  first word address, sampled with start.
REQ-008 SHALL have port word_count  input  ADDR_WIDTH+1  words to read (0 to 2^ADDR_WIDTH), sampled with start.
REQ-009 SHALL have port busy  output  1  transfer in progress.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port address  output  ADDR_WIDTH  memory word address.
REQ-012 SHALL have port chipselect  output  1  memory read strobe.
REQ-013 SHALL have port write  output  1  tied 0.
REQ-014 SHALL have port byteenable  output  4  tied 4'hF.
REQ-015 SHALL have port clken  output  1  tied 1.
REQ-016 SHALL have port readdata  input  32  memory data, valid exactly one cycle after chipselect.
REQ-017 SHALL have port st_data  output  32  stream data.
REQ-018 SHALL have port st_valid  output  1  stream data valid.
REQ-019 SHALL have port st_ready  input  1  downstream accept.
REQ-020 SHALL have port st_startofpacket  output  1  first word of the transfer.
REQ-021 SHALL have port st_endofpacket  output  1  last word of the transfer.

Function
REQ-022 SHALL implement states IDLE, FETCH, DRAIN; busy = 1 in FETCH and DRAIN.
REQ-023 IDLE with start=1 and word_count>0 SHALL latch base_address/word_count, clear the issue counter, and go to FETCH.
REQ-024 IDLE with start=1 and word_count=0 SHALL pulse done on the next cycle, issue no read, and stay in IDLE.
REQ-025 start while busy SHALL be ignored.
REQ-026 In FETCH, chipselect SHALL be 1 in a cycle iff issued<word_count and fifo_count+inflight<FIFO_DEPTH; inflight = chipselect registered from the previous cycle.
REQ-027 address SHALL equal base+issued modulo 2^ADDR_WIDTH (wrap 0xFFF to 0x000).
REQ-028 readdata SHALL be written into the FIFO on the cycle after each chipselect cycle; the block SHALL never drop or duplicate a word.
REQ-029 FETCH SHALL go to DRAIN on the edge where the last read is issued.
REQ-030 DRAIN SHALL go to IDLE, pulsing done for one cycle, on the cycle after the last word's st_valid&st_ready handshake.
REQ-031 st_valid SHALL equal FIFO not-empty, and st_data SHALL be the FIFO head; a word pops on st_valid&st_ready; st_data/SOP/EOP SHALL be stable while st_valid&!st_ready.
REQ-032 st_startofpacket SHALL be 1 with word 0; st_endofpacket SHALL be 1 with word word_count-1; both SHALL be 1 on the same word when word_count=1.
REQ-033 Latency: the first st_valid SHALL assert 3 edges after start is sampled (chipselect after edge 1, capture at edge 2, valid after edge 3).
REQ-034 With st_ready held 1, throughput SHALL be one word per clock.
REQ-035 A FIFO push and pop in the same cycle SHALL leave fifo_count unchanged.

Reset
REQ-036 reset_n=0 SHALL asynchronously force IDLE, empty the FIFO, and clear counters; busy, done, chipselect, st_valid, st_startofpacket and st_endofpacket SHALL be 0; address SHALL be 0.
REQ-037 Reset mid-transfer SHALL abandon the transfer with no done pulse; a start after reset release SHALL operate normally.

Verification
REQ-038 base=0x010, count=4, st_ready=1 -> address 0x010..0x013 on 4 consecutive chipselect cycles; st_data = mem[0x010..0x013]; SOP on word 0; EOP on word 3; done 1 cycle after the last handshake.
REQ-039 base=0xFFE, count=4 -> addresses 0xFFE, 0xFFF, 0x000, 0x001 in order; data matches.
REQ-040 count=16, st_ready=0 after the first word for 20 cycles -> at most FIFO_DEPTH words buffered; chipselect stalls; all 16 words are delivered in order once st_ready=1.
REQ-041 count=0 -> done pulses 1 cycle after start; chipselect and busy never assert.
REQ-042 start pulsed again mid-transfer -> ignored; reset_n low mid-transfer -> busy, chipselect and st_valid go to 0 immediately, no done; a new start with count=2 completes correctly.
REQ-043 count=4096, random st_ready -> all 4096 words in address order; exactly one SOP, one EOP and one done.
